// File: rtl/simon_pkg.sv
// Shared types and colour helpers for the Simon Says round controller.
package simon_pkg;

    typedef enum logic [2:0] {
        IDLE,
        GAP,
        SHOW_ON,
        SHOW_OFF,
        WAIT_PRESS,
        WAIT_RELEASE,
        WIN,
        LOSE
    } state_t;

    typedef struct packed {
        logic       valid;
        logic [1:0] code;
    } colour_t;

    // Codes 4-7 are not colours; they decode as invalid and never light or match.
    function automatic colour_t decode_colour(input logic [2:0] raw);
        colour_t c;
        c.valid = ~raw[2];
        c.code  = raw[1:0];
        return c;
    endfunction

    function automatic logic [3:0] onehot4(input colour_t c);
        return c.valid ? (4'b0001 << c.code) : 4'b0000;
    endfunction

endpackage

// File: rtl/simon_sequencer_if.sv
// Game-facing signal bundle: controls and sequence in, display and status out.
interface simon_sequencer_if #(
    parameter int MAX_ROUNDS = 32
);
    localparam int IDX_W = $clog2(MAX_ROUNDS);
    localparam int RND_W = $clog2(MAX_ROUNDS + 1);

    logic                         start;
    logic [MAX_ROUNDS-1:0][2:0]   seq;
    logic [3:0]                   player_input;
    logic [3:0]                   flash;
    logic                         flash_strobe;
    logic [IDX_W-1:0]             check_round;
    logic [RND_W-1:0]             round;
    logic                         busy;
    logic                         win;
    logic                         lose;

    modport master (
        output start, seq, player_input,
        input  flash, flash_strobe, check_round, round, busy, win, lose
    );

    modport slave (
        input  start, seq, player_input,
        output flash, flash_strobe, check_round, round, busy, win, lose
    );
endinterface

// File: rtl/phase_timer.sv
// Loadable saturating down-counter; done is high while the count is zero.
module phase_timer #(
    parameter int WIDTH = 10
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             en,
    output logic             done
);
    logic [WIDTH-1:0] count_q, count_d;

    // NOTE: every always_comb output gets a default first so no path infers a latch.
    always_comb begin
        count_d = count_q;
        if (load) begin
            count_d = load_val;
        end else if (en && count_q != '0) begin
            count_d = count_q - 1'b1;
        end
    end

    // NOTE: non-blocking so every flop updates from the values present before the edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign done = (count_q == '0);
endmodule

// File: rtl/simon_sequencer.sv
// Simon Says round controller: plays back the first N colours, then checks the presses.
module simon_sequencer
    import simon_pkg::*;
#(
    parameter int ON_CYCLES      = 8,
    parameter int OFF_CYCLES     = 4,
    parameter int MAX_ROUNDS     = 32,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic              clk,
    input  logic              reset,
    simon_sequencer_if.slave  bus
);
    localparam int IDX_W    = $clog2(MAX_ROUNDS);
    localparam int RND_W    = $clog2(MAX_ROUNDS + 1);
    localparam int SHOW_MAX = (ON_CYCLES > OFF_CYCLES) ? ON_CYCLES : OFF_CYCLES;
    localparam int TMR_MAX  = (TIMEOUT_CYCLES > SHOW_MAX) ? TIMEOUT_CYCLES : SHOW_MAX;
    localparam int TMR_W    = (TMR_MAX > 1) ? $clog2(TMR_MAX) : 1;

    // Timer holds (duration - 1) on entry so a phase lasts exactly its duration.
    localparam logic [TMR_W-1:0] ON_LOAD    = TMR_W'(ON_CYCLES - 1);
    localparam logic [TMR_W-1:0] OFF_LOAD   = TMR_W'(OFF_CYCLES - 1);
    localparam logic [TMR_W-1:0] PRESS_LOAD = TMR_W'(TIMEOUT_CYCLES - 1);
    localparam logic [RND_W-1:0] LAST_ROUND = RND_W'(MAX_ROUNDS);

    state_t           state_q, state_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [RND_W-1:0] round_q, round_d;
    logic             strobe_q, strobe_d;

    logic             tmr_load, tmr_en, tmr_done;
    logic [TMR_W-1:0] tmr_val;
    logic [3:0]       expected;
    logic             idx_is_last;

    phase_timer #(.WIDTH(TMR_W)) u_timer (
        .clk      (clk),
        .reset    (reset),
        .load     (tmr_load),
        .load_val (tmr_val),
        .en       (tmr_en),
        .done     (tmr_done)
    );

    assign expected    = onehot4(decode_colour(bus.seq[idx_q]));
    assign idx_is_last = ((RND_W'(idx_q) + RND_W'(1)) == round_q);

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= IDLE;
            idx_q    <= '0;
            round_q  <= '0;
            strobe_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            round_q  <= round_d;
            strobe_q <= strobe_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        round_d  = round_q;
        tmr_load = 1'b0;
        tmr_val  = '0;
        tmr_en   = (state_q inside {GAP, SHOW_ON, SHOW_OFF}) ||
                   (state_q == WAIT_PRESS && bus.player_input == 4'b0000);

        unique case (state_q)
            IDLE, WIN, LOSE: begin
                if (bus.start) begin
                    state_d  = GAP;
                    round_d  = RND_W'(1);
                    idx_d    = '0;
                    tmr_load = 1'b1;
                    tmr_val  = OFF_LOAD;
                end
            end
            GAP: begin
                if (tmr_done) begin
                    state_d  = SHOW_ON;
                    tmr_load = 1'b1;
                    tmr_val  = ON_LOAD;
                end
            end
            SHOW_ON: begin
                if (tmr_done) begin
                    state_d  = SHOW_OFF;
                    tmr_load = 1'b1;
                    tmr_val  = OFF_LOAD;
                end
            end
            SHOW_OFF: begin
                if (tmr_done) begin
                    tmr_load = 1'b1;
                    if (idx_is_last) begin
                        state_d = WAIT_PRESS;
                        idx_d   = '0;
                        tmr_val = PRESS_LOAD;
                    end else begin
                        state_d = SHOW_ON;
                        idx_d   = idx_q + 1'b1;
                        tmr_val = ON_LOAD;
                    end
                end
            end
            WAIT_PRESS: begin
                // An invalid entry expects 4'b0000, which no nonzero press can equal.
                if (bus.player_input != 4'b0000) begin
                    state_d = (bus.player_input == expected) ? WAIT_RELEASE : LOSE;
                end else if (tmr_done) begin
                    state_d = LOSE;
                end
            end
            WAIT_RELEASE: begin
                if (bus.player_input == 4'b0000) begin
                    if (!idx_is_last) begin
                        state_d  = WAIT_PRESS;
                        idx_d    = idx_q + 1'b1;
                        tmr_load = 1'b1;
                        tmr_val  = PRESS_LOAD;
                    end else if (round_q == LAST_ROUND) begin
                        state_d = WIN;
                    end else begin
                        state_d  = GAP;
                        round_d  = round_q + 1'b1;
                        idx_d    = '0;
                        tmr_load = 1'b1;
                        tmr_val  = OFF_LOAD;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        strobe_d = (state_d == SHOW_ON) && (state_q != SHOW_ON);
    end

    always_comb begin
        bus.flash        = (state_q == SHOW_ON) ? expected : 4'b0000;
        bus.flash_strobe = strobe_q;
        bus.check_round  = idx_q;
        bus.round        = round_q;
        bus.busy         = !(state_q inside {IDLE, WIN, LOSE});
        bus.win          = (state_q == WIN);
        bus.lose         = (state_q == LOSE);
    end
endmodule

// File: tb/tb_simon_sequencer.sv
// Bench for simon_sequencer: directed game scenarios plus random games, checked every cycle
// against a closed-form playback/press model.
module tb_simon_sequencer;
    localparam int ON     = 4;
    localparam int OFF    = 2;
    localparam int TO     = 16;
    localparam int MR     = 4;
    localparam int PERIOD = ON + OFF;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    simon_sequencer_if #(.MAX_ROUNDS(MR)) bus ();

    simon_sequencer #(
        .ON_CYCLES      (ON),
        .OFF_CYCLES     (OFF),
        .MAX_ROUNDS     (MR),
        .TIMEOUT_CYCLES (TO)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int n_checks = 0;
    int n_errors = 0;
    bit cmp_en   = 1'b0;

    typedef enum {M_IDLE, M_PLAY, M_WAIT, M_HELD, M_WIN, M_LOSE} mmode_t;
    mmode_t m_mode = M_IDLE;
    int m_n    = 0;
    int m_t    = 0;
    int m_pos  = 0;
    int m_idle = 0;

    function automatic logic [3:0] colour_onehot(input logic [2:0] c);
        logic [3:0] r;
        r = 4'b0000;
        if (c < 3'd4) r[c[1:0]] = 1'b1;
        return r;
    endfunction

    // Packed as {flash, strobe, check_round, round, busy, win, lose}.
    function automatic logic [31:0] dut_vec();
        return 32'({bus.flash, bus.flash_strobe, bus.check_round, bus.round,
                    bus.busy, bus.win, bus.lose});
    endfunction

    // Playback timeline: OFF dark cycles, then per entry ON lit + OFF dark.
    function automatic logic [31:0] model_vec();
        logic [3:0] f;
        logic       s, b, w, l;
        int         cr, u;
        f = 4'b0000; s = 1'b0; b = 1'b0; w = 1'b0; l = 1'b0; cr = m_pos;
        case (m_mode)
            M_PLAY: begin
                b  = 1'b1;
                cr = 0;
                if (m_t >= OFF) begin
                    u  = m_t - OFF;
                    cr = u / PERIOD;
                    if (u % PERIOD < ON) begin
                        f = colour_onehot(bus.seq[cr]);
                        s = (u % PERIOD == 0);
                    end
                end
            end
            M_WAIT, M_HELD: b = 1'b1;
            M_WIN:          w = 1'b1;
            M_LOSE:         l = 1'b1;
            default: ;
        endcase
        return 32'({f, s, cr[1:0], m_n[2:0], b, w, l});
    endfunction

    always @(posedge clk) begin
        if (reset) begin
            m_mode <= M_IDLE; m_n <= 0; m_t <= 0; m_pos <= 0; m_idle <= 0;
        end else begin
            case (m_mode)
                M_IDLE, M_WIN, M_LOSE: if (bus.start) begin
                    m_mode <= M_PLAY; m_n <= 1; m_t <= 0; m_pos <= 0;
                end
                M_PLAY: begin
                    m_t <= m_t + 1;
                    if (m_t + 1 == OFF + m_n * PERIOD) begin
                        m_mode <= M_WAIT; m_pos <= 0; m_idle <= 0;
                    end
                end
                M_WAIT: begin
                    if (bus.player_input != 4'b0000) begin
                        m_mode <= (bus.player_input == colour_onehot(bus.seq[m_pos])) ? M_HELD : M_LOSE;
                    end else begin
                        m_idle <= m_idle + 1;
                        if (m_idle + 1 == TO) m_mode <= M_LOSE;
                    end
                end
                M_HELD: if (bus.player_input == 4'b0000) begin
                    if (m_pos < m_n - 1) begin
                        m_pos <= m_pos + 1; m_idle <= 0; m_mode <= M_WAIT;
                    end else if (m_n == MR) begin
                        m_mode <= M_WIN;
                    end else begin
                        m_n <= m_n + 1; m_t <= 0; m_pos <= 0; m_mode <= M_PLAY;
                    end
                end
                default: ;
            endcase
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (cmp_en) check("cycle", dut_vec(), model_vec());
    end

    task automatic step();
        @(negedge clk);
    endtask

    task automatic pulse_start();
        bus.start = 1'b1;
        step();
        bus.start = 1'b0;
    endtask

    task automatic wait_press_phase();
        int k = 0;
        while (m_mode != M_WAIT && k < 500) begin
            step();
            k++;
        end
        if (m_mode != M_WAIT) begin
            n_checks++;
            n_errors++;
            $display("FAIL wait_press_bound: press phase not reached within 500 cycles");
        end
    endtask

    task automatic do_press(input logic [3:0] val, input int hold);
        bus.player_input = val;
        repeat (hold) step();
        bus.player_input = 4'b0000;
        step();
    endtask

    // Correct press with a random lead-in; extra buttons while held must be ignored.
    task automatic press_correct();
        logic [3:0] val;
        int         hold;
        repeat ($urandom_range(0, 4)) step();
        val = colour_onehot(bus.seq[m_pos]);
        if (val == 4'b0000) val = 4'b0010;
        hold = $urandom_range(1, 3);
        bus.player_input = val;
        step();
        for (int h = 1; h < hold; h++) begin
            bus.player_input = val | 4'($urandom_range(0, 15));
            step();
        end
        bus.player_input = 4'b0000;
        step();
    endtask

    task automatic play_round_ok();
        int n;
        wait_press_phase();
        n = m_n;
        for (int p = 0; p < n; p++) press_correct();
    endtask

    task automatic set_seq(input logic [2:0] a, input logic [2:0] b,
                           input logic [2:0] c, input logic [2:0] d);
        bus.seq[0] = a; bus.seq[1] = b; bus.seq[2] = c; bus.seq[3] = d;
    endtask

    initial begin
        logic [31:0] mv;
        logic [3:0]  v;
        int          r, guard, k;

        reset = 1'b1;
        bus.start = 1'b0;
        bus.player_input = 4'b0000;
        set_seq(3'd0, 3'd1, 3'd2, 3'd3);
        repeat (3) step();
        cmp_en = 1'b1;
        check("reset_outputs", dut_vec(), 32'h0);
        reset = 1'b0;

        // Round 1 playback: two dark cycles, then 0001 for four cycles.
        pulse_start();
        check("gap_dark", 32'(bus.flash), 32'h0);
        repeat (2) step();
        check("first_flash", 32'(bus.flash), 32'h1);
        check("strobe_first", 32'(bus.flash_strobe), 32'h1);
        step();
        check("strobe_once", 32'(bus.flash_strobe), 32'h0);
        repeat (5) step();
        check("wait_idx", 32'(bus.check_round), 32'h0);
        check("wait_round", 32'(bus.round), 32'h1);
        check("wait_busy", 32'(bus.busy), 32'h1);

        // Timeout after 16 idle cycles, then restart.
        repeat (15) step();
        check("no_early_timeout", 32'(bus.lose), 32'h0);
        step();
        check("timeout_lose", 32'(bus.lose), 32'h1);
        check("timeout_busy", 32'(bus.busy), 32'h0);
        pulse_start();
        check("restart_lose", 32'(bus.lose), 32'h0);
        check("restart_round", 32'(bus.round), 32'h1);

        // Round 1 correct, round 2 wrong on the second press with a stray start.
        wait_press_phase();
        do_press(4'b0001, 2);
        check("round_two", 32'(bus.round), 32'h2);
        wait_press_phase();
        do_press(4'b0001, 1);
        bus.player_input = 4'b0100;
        bus.start = 1'b1;
        step();
        bus.start = 1'b0;
        bus.player_input = 4'b0000;
        check("wrong_lose", 32'(bus.lose), 32'h1);
        check("wrong_round", 32'(bus.round), 32'h2);
        check("wrong_flash", 32'(bus.flash), 32'h0);
        check("wrong_busy", 32'(bus.busy), 32'h0);
        step();

        // Full game to WIN, then a two-button press loses.
        pulse_start();
        repeat (MR) play_round_ok();
        check("win_flag", 32'(bus.win), 32'h1);
        check("win_round", 32'(bus.round), 32'h4);
        pulse_start();
        check("win_cleared", 32'(bus.win), 32'h0);
        wait_press_phase();
        do_press(4'b0011, 1);
        check("double_press_lose", 32'(bus.lose), 32'h1);

        // Reset while round 3 is lighting an entry.
        pulse_start();
        play_round_ok();
        play_round_ok();
        k = 0;
        mv = model_vec();
        while (!(m_n == 3 && mv[12:9] != 4'b0000) && k < 300) begin
            step();
            mv = model_vec();
            k++;
        end
        check("reached_round3_show", 32'(bus.round), 32'h3);
        reset = 1'b1;
        step();
        reset = 1'b0;
        check("reset_mid_show", dut_vec(), 32'h0);

        // Invalid code: dark for the whole show slot, and no press can match it.
        set_seq(3'd5, 3'd1, 3'd2, 3'd3);
        pulse_start();
        repeat (2) step();
        check("invalid_dark", 32'(bus.flash), 32'h0);
        check("invalid_strobe", 32'(bus.flash_strobe), 32'h1);
        wait_press_phase();
        do_press(4'b0010, 1);
        check("invalid_lose", 32'(bus.lose), 32'h1);

        for (int g = 0; g < 25; g++) begin
            for (int i = 0; i < MR; i++) begin
                bus.seq[i] = ($urandom_range(0, 9) == 0) ? 3'($urandom_range(4, 7))
                                                         : 3'($urandom_range(0, 3));
            end
            pulse_start();
            guard = 0;
            while (m_mode != M_WIN && m_mode != M_LOSE && m_mode != M_IDLE && guard < 3000) begin
                guard++;
                if (m_mode == M_WAIT) begin
                    r = $urandom_range(0, 99);
                    if (r < 4) begin
                        repeat (TO) step();
                    end else if (r < 10) begin
                        v = 4'($urandom_range(1, 15));
                        if (v == colour_onehot(bus.seq[m_pos])) v = 4'b1111;
                        bus.player_input = v;
                        bus.start = 1'($urandom_range(0, 1));
                        step();
                        bus.start = 1'b0;
                        bus.player_input = 4'b0000;
                    end else begin
                        press_correct();
                    end
                end else begin
                    r = $urandom_range(0, 199);
                    if (r == 0) begin
                        reset = 1'b1;
                        step();
                        reset = 1'b0;
                    end else begin
                        bus.start = (r < 10);
                        step();
                        bus.start = 1'b0;
                    end
                end
            end
            if (guard >= 3000) begin
                n_checks++;
                n_errors++;
                $display("FAIL game_bound: game %0d did not end", g);
            end
            step();
        end

        cmp_en = 1'b0;
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
